// File: rtl/nes_button_events_pkg.sv
// nes_button_events_pkg
//   Shared constants and types for the NES button event block.
//   Button bit map of a controller snapshot (1 = pressed):
//     bit 0 A, 1 B, 2 Select, 3 Start, 4 Up, 5 Down, 6 Left, 7 Right.
//   An event word is {type[1:0], index[2:0]}.
package nes_button_events_pkg;

  localparam int NES_NUM_BTN    = 8;
  // D-pad occupies the upper nibble; only those bits auto-repeat.
  localparam int NES_DPAD_FIRST = 4;
  localparam int NES_NUM_DPAD   = 4;

  typedef logic [1:0] evt_type_t;
  typedef logic [4:0] event_t;

  localparam evt_type_t NES_EVT_NONE    = 2'b00;
  localparam evt_type_t NES_EVT_PRESS   = 2'b01;
  localparam evt_type_t NES_EVT_RELEASE = 2'b10;
  localparam evt_type_t NES_EVT_REPEAT  = 2'b11;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SCAN = 1'b1
  } state_t;

  function automatic event_t make_event(input evt_type_t t, input logic [2:0] idx);
    return {t, idx};
  endfunction

endpackage

// File: rtl/nes_button_events_sync_fifo.sv
// sync_fifo
//   Single-clock first-word-fall-through FIFO. The head entry is always
//   visible on o_data straight from the storage registers.
//   Ports:
//     clk         clock
//     i_rst       synchronous active-high reset (empties, clears storage)
//     i_push      write i_push_data; ignored when full at cycle start
//     i_push_data write data
//     i_pop       drop the head entry; ignored when empty
//     o_data      head entry
//     o_full      DEPTH entries held
//     o_empty     no entries held
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic             clk,
  input  logic             i_rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_push_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [DEPTH-1:0][WIDTH-1:0] mem_q;
  logic [AW-1:0]               wr_ptr_q;
  logic [AW-1:0]               rd_ptr_q;
  logic [AW:0]                 count_q;
  logic                        push_acc;
  logic                        pop_acc;

  assign o_full  = (count_q == (AW+1)'(DEPTH));
  assign o_empty = (count_q == '0);
  assign o_data  = mem_q[rd_ptr_q];

  // Full is judged on start-of-cycle occupancy, so a pop in the same
  // cycle never makes room for a push into a full FIFO.
  assign push_acc = i_push & ~o_full;
  assign pop_acc  = i_pop & ~o_empty;

  always_ff @(posedge clk) begin
    if (i_rst) begin
      mem_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_acc) begin
        mem_q[wr_ptr_q] <= i_push_data;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (pop_acc) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      case ({push_acc, pop_acc})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/nes_button_events.sv
// nes_button_events
//   Turns raw controller snapshots into a buffered stream of PRESS,
//   RELEASE and D-pad auto-REPEAT events on a valid/ready port.
//   Ports:
//     clk            clock
//     i_rst          synchronous active-high reset
//     i_valid        new snapshot strobe
//     i_buttons      snapshot, 1 = pressed
//     o_held         last accepted snapshot
//     o_event_valid  event FIFO head valid
//     o_event_data   head event {type, index}
//     i_event_ready  consumer pops head when valid and ready
//     o_overflow     sticky: event dropped on full FIFO
//     o_sample_drop  sticky: snapshot ignored during a scan
//
//   state | meaning
//   IDLE  | waiting for a snapshot; accepts it and latches pending events
//   SCAN  | walks index 0..7, one per cycle, pushing pending events
module nes_button_events
  import nes_button_events_pkg::*;
#(
  parameter int unsigned REPEAT_DELAY = 30,
  parameter int unsigned REPEAT_RATE  = 6,
  parameter int unsigned FIFO_DEPTH   = 8
) (
  input  logic       clk,
  input  logic       i_rst,
  input  logic       i_valid,
  input  logic [7:0] i_buttons,
  output logic [7:0] o_held,
  output logic       o_event_valid,
  output logic [4:0] o_event_data,
  input  logic       i_event_ready,
  output logic       o_overflow,
  output logic       o_sample_drop
);

  localparam logic [7:0] DELAY8 = 8'(REPEAT_DELAY);
  localparam logic [7:0] RATE8  = 8'(REPEAT_RATE);

  state_t                                 state_q;
  logic [2:0]                             idx_q;
  logic [NES_NUM_BTN-1:0]                 held_q, held_d;
  logic [NES_NUM_BTN-1:0][1:0]            pend_q, pend_d;
  logic [NES_NUM_DPAD-1:0][7:0]           cnt_q, cnt_d;
  logic                                   overflow_q;
  logic                                   sample_drop_q;

  logic [NES_NUM_BTN-1:0] rise, fall, stay;
  logic                   accept;
  logic                   push_valid;
  event_t                 push_data;
  logic                   fifo_full;
  logic                   fifo_empty;

  assign accept = (state_q == ST_IDLE) && i_valid;
  assign rise   = i_buttons & ~held_q;
  assign fall   = ~i_buttons & held_q;
  assign stay   = i_buttons & held_q;

  // Pending types and repeat counters only move when a snapshot is accepted.
  always_comb begin
    held_d = held_q;
    pend_d = pend_q;
    cnt_d  = cnt_q;
    if (accept) begin
      held_d = i_buttons;
      for (int b = 0; b < NES_NUM_BTN; b++) begin
        if (rise[b])      pend_d[b] = NES_EVT_PRESS;
        else if (fall[b]) pend_d[b] = NES_EVT_RELEASE;
        else              pend_d[b] = NES_EVT_NONE;
      end
      for (int d = 0; d < NES_NUM_DPAD; d++) begin
        if (rise[NES_DPAD_FIRST+d]) begin
          cnt_d[d] = DELAY8;
        end else if (fall[NES_DPAD_FIRST+d]) begin
          cnt_d[d] = 8'd0;
        end else if (stay[NES_DPAD_FIRST+d]) begin
          if (cnt_q[d] == 8'd1) begin
            pend_d[NES_DPAD_FIRST+d] = NES_EVT_REPEAT;
            cnt_d[d]                 = RATE8;
          end else if (cnt_q[d] > 8'd1) begin
            cnt_d[d] = cnt_q[d] - 8'd1;
          end
        end
      end
    end
  end

  assign push_valid = (state_q == ST_SCAN) && (pend_q[idx_q] != NES_EVT_NONE);
  assign push_data  = make_event(pend_q[idx_q], idx_q);

  always_ff @(posedge clk) begin
    if (i_rst) begin
      state_q       <= ST_IDLE;
      idx_q         <= 3'd0;
      held_q        <= '0;
      pend_q        <= '0;
      cnt_q         <= '0;
      overflow_q    <= 1'b0;
      sample_drop_q <= 1'b0;
    end else begin
      held_q <= held_d;
      pend_q <= pend_d;
      cnt_q  <= cnt_d;
      if (push_valid && fifo_full) begin
        overflow_q <= 1'b1;
      end
      case (state_q)
        ST_IDLE: begin
          if (i_valid) begin
            state_q <= ST_SCAN;
            idx_q   <= 3'd0;
          end
        end
        ST_SCAN: begin
          if (i_valid) begin
            sample_drop_q <= 1'b1;
          end
          idx_q <= idx_q + 3'd1;
          if (idx_q == 3'd7) begin
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  sync_fifo #(
    .WIDTH(5),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .i_rst       (i_rst),
    .i_push      (push_valid),
    .i_push_data (push_data),
    .i_pop       (i_event_ready),
    .o_data      (o_event_data),
    .o_full      (fifo_full),
    .o_empty     (fifo_empty)
  );

  assign o_event_valid = ~fifo_empty;
  assign o_held        = held_q;
  assign o_overflow    = overflow_q;
  assign o_sample_drop = sample_drop_q;

endmodule

// File: tb/tb_nes_button_events.sv
// tb_nes_button_events
//   Directed stimulus with a scoreboard: expected events are queued when a
//   snapshot is issued; a monitor pops and compares on each handshake.
module tb_nes_button_events;

  logic       clk = 1'b0;
  logic       i_rst;
  logic       i_valid;
  logic [7:0] i_buttons;
  logic [7:0] o_held;
  logic       o_event_valid;
  logic [4:0] o_event_data;
  logic       i_event_ready;
  logic       o_overflow;
  logic       o_sample_drop;

  int         checks = 0;
  int         errors = 0;
  logic [4:0] exp_q[$];
  logic [4:0] exp_ev;

  always #5 clk = ~clk;

  nes_button_events #(
    .REPEAT_DELAY(3),
    .REPEAT_RATE (2),
    .FIFO_DEPTH  (4)
  ) dut (
    .clk           (clk),
    .i_rst         (i_rst),
    .i_valid       (i_valid),
    .i_buttons     (i_buttons),
    .o_held        (o_held),
    .o_event_valid (o_event_valid),
    .o_event_data  (o_event_data),
    .i_event_ready (i_event_ready),
    .o_overflow    (o_overflow),
    .o_sample_drop (o_sample_drop)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every handshake seen mid-cycle is one popped event.
  always @(negedge clk) begin
    if (!i_rst && o_event_valid && i_event_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL event_unexpected: got %b expected none", o_event_data);
      end else begin
        exp_ev = exp_q.pop_front();
        if (o_event_data !== exp_ev) begin
          errors++;
          $display("FAIL event_data: got %b expected %b", o_event_data, exp_ev);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Returns just after the edge that samples the snapshot (start of cycle 1).
  task automatic send(input logic [7:0] b);
    i_buttons = b;
    i_valid   = 1'b1;
    @(posedge clk);
    #1;
    i_valid   = 1'b0;
  endtask

  task automatic do_reset();
    i_rst         = 1'b1;
    i_valid       = 1'b0;
    i_buttons     = 8'h00;
    i_event_ready = 1'b0;
    tick(2);
    i_rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    do_reset();
    chk("rst_held", o_held, 8'h00);
    chk("rst_valid", o_event_valid, 1'b0);
    chk("rst_data", o_event_data, 5'b00000);
    chk("rst_overflow", o_overflow, 1'b0);
    chk("rst_sample_drop", o_sample_drop, 1'b0);

    // Edge events with first-event latency
    i_event_ready = 1'b1;
    exp_q.push_back(5'b01_000);
    send(8'h01);
    chk("held_press_a", o_held, 8'h01);
    chk("latency_cycle1", o_event_valid, 1'b0);
    tick(1);
    chk("latency_cycle2", o_event_valid, 1'b1);
    tick(8);
    exp_q.push_back(5'b10_000);
    send(8'h00);
    chk("held_release_a", o_held, 8'h00);
    tick(9);

    // Multi-bit ordering
    exp_q.push_back(5'b01_000);
    exp_q.push_back(5'b01_100);
    exp_q.push_back(5'b01_111);
    send(8'h91);
    tick(9);
    exp_q.push_back(5'b10_000);
    exp_q.push_back(5'b10_100);
    exp_q.push_back(5'b10_111);
    send(8'h00);
    tick(9);

    // Auto-repeat: DELAY 3, RATE 2 -> REPEAT at snapshots 3, 5, 7
    do_reset();
    i_event_ready = 1'b1;
    for (int s = 0; s < 8; s++) begin
      if (s == 0) exp_q.push_back(5'b01_100);
      else if (s == 3 || s == 5 || s == 7) exp_q.push_back(5'b11_100);
      send(8'h10);
      tick(9);
    end
    exp_q.push_back(5'b10_100);
    send(8'h00);
    tick(9);

    // Sample drop: second strobe lands during cycle 3 of the scan
    do_reset();
    i_event_ready = 1'b1;
    exp_q.push_back(5'b01_001);
    send(8'h02);
    chk("drop_pre", o_sample_drop, 1'b0);
    tick(2);
    i_buttons = 8'h00;
    i_valid   = 1'b1;
    tick(1);
    i_valid   = 1'b0;
    chk("drop_flag", o_sample_drop, 1'b1);
    tick(8);
    chk("drop_held_unchanged", o_held, 8'h02);
    chk("drop_sticky", o_sample_drop, 1'b1);

    // Overflow with depth 4, consumer stalled
    do_reset();
    chk("overflow_pre", o_overflow, 1'b0);
    exp_q.push_back(5'b01_000);
    exp_q.push_back(5'b01_001);
    exp_q.push_back(5'b01_010);
    exp_q.push_back(5'b01_011);
    send(8'hFF);
    tick(9);
    chk("overflow_flag", o_overflow, 1'b1);
    chk("overflow_valid", o_event_valid, 1'b1);
    chk("overflow_head", o_event_data, 5'b01_000);
    // RELEASE A is pushed in the same cycle as the first pop while full: dropped.
    send(8'hFE);
    i_event_ready = 1'b1;
    chk("overflow_held", o_held, 8'hFE);
    tick(12);
    chk("overflow_drained", o_event_valid, 1'b0);
    chk("overflow_sticky", o_overflow, 1'b1);

    // Reset mid-scan
    do_reset();
    send(8'h0F);
    tick(3);
    i_rst = 1'b1;
    tick(1);
    chk("midrst_valid", o_event_valid, 1'b0);
    chk("midrst_held", o_held, 8'h00);
    chk("midrst_data", o_event_data, 5'b00000);
    i_rst         = 1'b0;
    i_event_ready = 1'b1;
    tick(20);
    chk("midrst_no_events", o_event_valid, 1'b0);

    chk("scoreboard_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
